mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single shared external memory port used by both instruction fetch and the MEM stage of the 5-stage pipeline. It grants the port to one requester at a time, holds the external transaction until acknowledged, returns read data with a one-cycle ready pulse, and generates the stall signals that freeze the PC/IF-ID registers and the EX/MEM pipeline register while an access is outstanding. A starvation counter and a watchdog timeout keep the pipeline from locking up.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared external memory port arbiter for instruction fetch and the MEM stage.
// Grants one requester at a time, sequences the external handshake and drives pipeline stalls.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic [31:0] ext_rdata,
    input  logic        ext_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        timeout_err
);

    localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BUSY_MAX   = BW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_MEM = 2'd1;
    localparam logic [1:0] BUSY_IF  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic [BW-1:0] busy_cnt_q, busy_cnt_d;
    logic          ext_req_d, ext_we_d, if_ready_d, mem_ready_d, timeout_err_d;
    logic [31:0]   ext_addr_d, ext_wdata_d, if_rdata_d, mem_rdata_d;

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        ext_req_d     = ext_req;
        ext_we_d      = ext_we;
        ext_addr_d    = ext_addr;
        ext_wdata_d   = ext_wdata;
        if_rdata_d    = if_rdata;
        mem_rdata_d   = mem_rdata;
        timeout_err_d = timeout_err;
        if_ready_d    = 1'b0;
        mem_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_cnt_d = '0;
                // MEM has priority until IF has lost STARVE_LIMIT arbitrations in a row
                if (mem_req && !(if_req && starve_cnt_q >= STARVE_MAX)) begin
                    state_d     = BUSY_MEM;
                    ext_req_d   = 1'b1;
                    ext_we_d    = mem_we;
                    ext_addr_d  = mem_addr;
                    ext_wdata_d = mem_wdata;
                    if (if_req && starve_cnt_q < STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d      = BUSY_IF;
                    ext_req_d    = 1'b1;
                    ext_we_d     = 1'b0;
                    ext_addr_d   = if_addr;
                    starve_cnt_d = '0;
                end
            end
            BUSY_MEM, BUSY_IF: begin
                busy_cnt_d = busy_cnt_q + 1'b1;
                // An ack on the watchdog's final cycle still completes normally
                if (ext_ack || busy_cnt_q == BUSY_MAX) begin
                    state_d   = IDLE;
                    ext_req_d = 1'b0;
                    ext_we_d  = 1'b0;
                    if (!ext_ack) begin
                        timeout_err_d = 1'b1;
                    end
                    if (state_q == BUSY_IF) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = ext_ack ? ext_rdata : 32'h0000_0000;
                    end else begin
                        mem_ready_d = 1'b1;
                        if (!ext_ack) begin
                            mem_rdata_d = 32'h0000_0000;
                        end else if (!ext_we) begin
                            mem_rdata_d = ext_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            busy_cnt_q   <= '0;
            ext_req      <= 1'b0;
            ext_we       <= 1'b0;
            ext_addr     <= 32'h0000_0000;
            ext_wdata    <= 32'h0000_0000;
            if_rdata     <= 32'h0000_0000;
            mem_rdata    <= 32'h0000_0000;
            if_ready     <= 1'b0;
            mem_ready    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            busy_cnt_q   <= busy_cnt_d;
            ext_req      <= ext_req_d;
            ext_we       <= ext_we_d;
            ext_addr     <= ext_addr_d;
            ext_wdata    <= ext_wdata_d;
            if_rdata     <= if_rdata_d;
            mem_rdata    <= mem_rdata_d;
            if_ready     <= if_ready_d;
            mem_ready    <= mem_ready_d;
            timeout_err  <= timeout_err_d;
        end
    end

    assign stall_mem = mem_req & ~mem_ready;
    assign stall_if  = (if_req & ~if_ready) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: load, store, contention,
// watchdog timeout, reset mid-access and ack/timeout tie.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    int checks;
    int errors;

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .ext_ack    (ext_ack),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        logic [31:0] exp_addr;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        ext_rdata = 32'h0;
        ext_ack   = 1'b0;

        tick();
        tick();
        check("rst_ext_req", {31'b0, ext_req}, 32'h0);
        check("rst_ext_addr", ext_addr, 32'h0);
        check("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_timeout", {31'b0, timeout_err}, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single load, acked on the third busy edge
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h100;
        #1;
        check("ld_stall_mem_req", {31'b0, stall_mem}, 32'h1);
        tick();
        check("ld_ext_req", {31'b0, ext_req}, 32'h1);
        check("ld_ext_addr", ext_addr, 32'h100);
        check("ld_ext_we", {31'b0, ext_we}, 32'h0);
        tick();
        tick();
        check("ld_no_ready_yet", {31'b0, mem_ready}, 32'h0);
        check("ld_stall_mem_busy", {31'b0, stall_mem}, 32'h1);
        ext_ack   = 1'b1;
        ext_rdata = 32'hCAFE_F00D;
        tick();
        check("ld_mem_ready", {31'b0, mem_ready}, 32'h1);
        check("ld_mem_rdata", mem_rdata, 32'hCAFE_F00D);
        check("ld_stall_mem_drop", {31'b0, stall_mem}, 32'h0);
        check("ld_ext_req_drop", {31'b0, ext_req}, 32'h0);
        mem_req = 1'b0;
        ext_ack = 1'b0;
        tick();
        check("ld_ready_single", {31'b0, mem_ready}, 32'h0);

        // Store: ext_we/ext_wdata driven, mem_rdata untouched
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = 32'h200;
        mem_wdata = 32'h1234_5678;
        tick();
        check("st_ext_we", {31'b0, ext_we}, 32'h1);
        check("st_ext_addr", ext_addr, 32'h200);
        check("st_ext_wdata", ext_wdata, 32'h1234_5678);
        ext_ack   = 1'b1;
        ext_rdata = 32'hDEAD_BEEF;
        tick();
        check("st_mem_ready", {31'b0, mem_ready}, 32'h1);
        check("st_mem_rdata_kept", mem_rdata, 32'hCAFE_F00D);
        mem_req = 1'b0;
        mem_we  = 1'b0;
        ext_ack = 1'b0;
        tick();

        // Contention with immediate acks: expect M,M,M,M,I,M
        if_req    = 1'b1;
        if_addr   = 32'h1000;
        mem_req   = 1'b1;
        mem_addr  = 32'h2000;
        ext_ack   = 1'b1;
        ext_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 6; i++) begin
            exp_addr = (i == 4) ? 32'h1000 : 32'h2000;
            tick();
            check($sformatf("arb%0d_addr", i), ext_addr, exp_addr);
            check($sformatf("arb%0d_ext_req", i), {31'b0, ext_req}, 32'h1);
            tick();
            check($sformatf("arb%0d_if_ready", i), {31'b0, if_ready}, (i == 4) ? 32'h1 : 32'h0);
            check($sformatf("arb%0d_mem_ready", i), {31'b0, mem_ready}, (i == 4) ? 32'h0 : 32'h1);
        end
        check("arb_if_rdata", if_rdata, 32'h0BAD_F00D);
        if_req  = 1'b0;
        mem_req = 1'b0;
        ext_ack = 1'b0;
        tick();

        // Watchdog: IF access never acked
        if_req  = 1'b1;
        if_addr = 32'h3000;
        tick();
        check("to_ext_addr", ext_addr, 32'h3000);
        pulses = 0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (if_ready) pulses++;
        end
        check("to_no_early_ready", pulses, 0);
        check("to_stall_if", {31'b0, stall_if}, 32'h1);
        tick();
        check("to_if_ready", {31'b0, if_ready}, 32'h1);
        check("to_if_rdata", if_rdata, 32'h0);
        check("to_err", {31'b0, timeout_err}, 32'h1);
        check("to_ext_req_drop", {31'b0, ext_req}, 32'h0);
        if_req = 1'b0;
        tick();
        ext_ack   = 1'b1;
        ext_rdata = 32'h5555_AAAA;
        tick();
        ext_ack = 1'b0;
        check("to_late_ack_ready", {31'b0, if_ready}, 32'h0);
        check("to_late_ack_req", {31'b0, ext_req}, 32'h0);
        tick();
        check("to_late_ack_rdata", if_rdata, 32'h0);
        check("to_err_sticky", {31'b0, timeout_err}, 32'h1);

        // Reset during BUSY_MEM, then a stray ack
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h400;
        tick();
        check("rm_ext_req", {31'b0, ext_req}, 32'h1);
        rst_n   = 1'b0;
        mem_req = 1'b0;
        #1;
        check("rm_ext_req_async", {31'b0, ext_req}, 32'h0);
        check("rm_ext_addr", ext_addr, 32'h0);
        check("rm_err_clear", {31'b0, timeout_err}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        ext_ack   = 1'b1;
        ext_rdata = 32'h7777_7777;
        tick();
        ext_ack = 1'b0;
        check("rm_no_ready", {31'b0, mem_ready}, 32'h0);
        check("rm_mem_rdata", mem_rdata, 32'h0);
        check("rm_ext_req_idle", {31'b0, ext_req}, 32'h0);

        // Ack on the same edge as the timeout: ack wins
        if_req  = 1'b1;
        if_addr = 32'h5000;
        tick();
        for (int i = 1; i < 64; i++) tick();
        ext_ack   = 1'b1;
        ext_rdata = 32'h600D_DA7A;
        tick();
        ext_ack = 1'b0;
        if_req  = 1'b0;
        check("tie_if_ready", {31'b0, if_ready}, 32'h1);
        check("tie_if_rdata", if_rdata, 32'h600D_DA7A);
        check("tie_no_err", {31'b0, timeout_err}, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
